// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage: mem_op codes, FSM states
// and small op-class helpers used by the decoder, EX/MEM and mem_stage.
package mem_stage_pkg;

    localparam logic [3:0] MEM_NONE = 4'd0;
    localparam logic [3:0] MEM_LW   = 4'd1;
    localparam logic [3:0] MEM_LH   = 4'd2;
    localparam logic [3:0] MEM_LHU  = 4'd3;
    localparam logic [3:0] MEM_LB   = 4'd4;
    localparam logic [3:0] MEM_LBU  = 4'd5;
    localparam logic [3:0] MEM_SW   = 4'd6;
    localparam logic [3:0] MEM_SH   = 4'd7;
    localparam logic [3:0] MEM_SB   = 4'd8;

    typedef enum logic {
        S_IDLE      = 1'b0,
        S_LOAD_WAIT = 1'b1
    } state_t;

    function automatic logic is_load(input logic [3:0] op);
        return (op >= MEM_LW) && (op <= MEM_LBU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= MEM_SW) && (op <= MEM_SB);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM-side inputs and MEM/WB-side outputs of the memory-access stage.
// master = pipeline driving the stage, slave = mem_stage itself.
interface mem_stage_if;
    logic        in_valid;
    logic [3:0]  mem_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        syscall;
    logic        WE;
    logic [3:0]  RW;
    logic        go;
    logic        flush;
    logic        stall;
    logic        out_valid;
    logic        misalign;
    logic        syscall_out;
    logic        WE_out;
    logic [3:0]  RW_out;
    logic [31:0] A_out;
    logic [31:0] w_out;

    modport master (
        output in_valid, mem_op, A, B, syscall, WE, RW, go, flush,
        input  stall, out_valid, misalign, syscall_out, WE_out, RW_out, A_out, w_out
    );

    modport slave (
        input  in_valid, mem_op, A, B, syscall, WE, RW, go, flush,
        output stall, out_valid, misalign, syscall_out, WE_out, RW_out, A_out, w_out
    );
endinterface

// File: rtl/mem_stage_data_ram.sv
// Data RAM: 2^ADDR_W x 32 with per-byte write enables and a registered read
// port whose output register is cleared by reset (the array itself is not).
module data_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              re,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q, rdata_d;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    // Read word is held until the next read so a stalled load stays stable.
    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem[addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: byte/halfword/word loads and stores on the data RAM,
// with a two-state FSM that stalls upstream while a synchronous read completes.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    mem_stage_if.slave bus
);
    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  lane_q, lane_d;
    logic        sys_q, sys_d;
    logic        we_q, we_d;
    logic [3:0]  rw_q, rw_d;
    logic [31:0] a_q, a_d;

    logic        ld_in, st_in, live, idle, issue;
    logic [1:0]  lane_in;
    logic [3:0]  be;
    logic [31:0] wdata, rdata;

    function automatic logic [31:0] extract(input logic [3:0] op, input logic [1:0] lane,
                                            input logic [31:0] word);
        logic [15:0] h;
        logic [7:0]  b;
        h = lane[1] ? word[31:16] : word[15:0];
        b = 8'(word >> {lane, 3'b000});
        case (op)
            MEM_LH:  return {{16{h[15]}}, h};
            MEM_LHU: return {16'h0000, h};
            MEM_LB:  return {{24{b[7]}}, b};
            MEM_LBU: return {24'h000000, b};
            default: return word;
        endcase
    endfunction

    // Lane selection with the ignored low address bits forced to zero.
    always_comb begin
        ld_in = is_load(bus.mem_op);
        st_in = is_store(bus.mem_op);
        live  = bus.in_valid & ~bus.flush;
        idle  = (state_q == S_IDLE);
        issue = rst_n & idle & live & ld_in;
        case (bus.mem_op)
            MEM_LW, MEM_SW:          lane_in = 2'b00;
            MEM_LH, MEM_LHU, MEM_SH: lane_in = {bus.A[1], 1'b0};
            default:                 lane_in = bus.A[1:0];
        endcase
        be    = 4'b0000;
        wdata = {4{bus.B[7:0]}};
        if (rst_n && idle && live && bus.go && st_in) begin
            case (bus.mem_op)
                MEM_SW: begin
                    be    = 4'b1111;
                    wdata = bus.B;
                end
                MEM_SH: begin
                    be    = lane_in[1] ? 4'b1100 : 4'b0011;
                    wdata = {2{bus.B[15:0]}};
                end
                default: be = 4'b0001 << lane_in;
            endcase
        end
    end

    data_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .re    (issue),
        .be    (be),
        .addr  (bus.A[ADDR_W+1:2]),
        .wdata (wdata),
        .rdata (rdata)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        lane_d  = lane_q;
        sys_d   = sys_q;
        we_d    = we_q;
        rw_d    = rw_q;
        a_d     = a_q;
        if (idle) begin
            if (issue) begin
                state_d = S_LOAD_WAIT;
                op_d    = bus.mem_op;
                lane_d  = lane_in;
                sys_d   = bus.syscall;
                we_d    = bus.WE;
                rw_d    = bus.RW;
                a_d     = bus.A;
            end
        end else if (bus.flush || bus.go) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= MEM_NONE;
            lane_q  <= 2'b00;
            sys_q   <= 1'b0;
            we_q    <= 1'b0;
            rw_q    <= 4'h0;
            a_q     <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            lane_q  <= lane_d;
            sys_q   <= sys_d;
            we_q    <= we_d;
            rw_q    <= rw_d;
            a_q     <= a_d;
        end
    end

    // Handshake outputs are forced quiet while reset is asserted.
    always_comb begin
        bus.misalign = rst_n & bus.in_valid &
                       ((((bus.mem_op == MEM_LW) || (bus.mem_op == MEM_SW)) && (bus.A[1:0] != 2'b00)) ||
                        (((bus.mem_op == MEM_LH) || (bus.mem_op == MEM_LHU) ||
                          (bus.mem_op == MEM_SH)) && bus.A[0]));
        if (idle) begin
            bus.out_valid   = rst_n & live & ~ld_in;
            bus.stall       = rst_n & live & ld_in;
            bus.w_out       = bus.A;
            bus.syscall_out = bus.syscall;
            bus.WE_out      = bus.WE;
            bus.RW_out      = bus.RW;
            bus.A_out       = bus.A;
        end else begin
            bus.out_valid   = rst_n & ~bus.flush;
            bus.stall       = rst_n & ~bus.flush & ~bus.go;
            bus.w_out       = extract(op_q, lane_q, rdata);
            bus.syscall_out = sys_q;
            bus.WE_out      = we_q;
            bus.RW_out      = rw_q;
            bus.A_out       = a_q;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: byte-array memory model plus per-cycle
// compare process, with hand-computed expectations along the directed sequence.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int ADDR_W = 10;
    localparam int MSZ    = (1 << ADDR_W) * 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    mem_stage_if bus();

    mem_stage #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0]  mb [int];
    bit          p_on = 1'b0;
    logic [3:0]  p_op, p_rw;
    logic [31:0] p_a;
    logic        p_sys, p_we;

    function automatic logic [7:0] rb(input int k);
        return mb.exists(k % MSZ) ? mb[k % MSZ] : 8'h00;
    endfunction

    function automatic logic [31:0] mload(input logic [3:0] op, input logic [31:0] a);
        int          ba, w, h;
        logic [15:0] hv;
        logic [7:0]  bv;
        ba = int'(a[ADDR_W+1:0]);
        w  = ba & ~3;
        h  = ba & ~1;
        hv = {rb(h + 1), rb(h)};
        bv = rb(ba);
        case (op)
            MEM_LW:  return {rb(w + 3), rb(w + 2), rb(w + 1), rb(w)};
            MEM_LH:  return {{16{hv[15]}}, hv};
            MEM_LHU: return {16'h0000, hv};
            MEM_LB:  return {{24{bv[7]}}, bv};
            MEM_LBU: return {24'h000000, bv};
            default: return a;
        endcase
    endfunction

    task automatic mstore(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
        int ba;
        ba = int'(a[ADDR_W+1:0]);
        case (op)
            MEM_SW:  for (int i = 0; i < 4; i++) mb[(ba & ~3) + i] = d[8*i +: 8];
            MEM_SH:  for (int i = 0; i < 2; i++) mb[(ba & ~1) + i] = d[8*i +: 8];
            default: mb[ba] = d[7:0];
        endcase
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            p_on = 1'b0;
        end else if (p_on) begin
            if (bus.flush || bus.go) p_on = 1'b0;
        end else if (bus.in_valid && !bus.flush) begin
            if (is_load(bus.mem_op)) begin
                p_on  = 1'b1;
                p_op  = bus.mem_op;
                p_a   = bus.A;
                p_sys = bus.syscall;
                p_we  = bus.WE;
                p_rw  = bus.RW;
            end else if (is_store(bus.mem_op) && bus.go) begin
                mstore(bus.mem_op, bus.A, bus.B);
            end
        end
    end

    always @(negedge clk) begin
        logic e_ov, e_st, e_mis, e_sys, e_we;
        logic [3:0]  e_rw;
        logic [31:0] e_w, e_a;
        e_mis = rst_n && bus.in_valid &&
                ((((bus.mem_op == MEM_LW) || (bus.mem_op == MEM_SW)) && (bus.A[1:0] != 0)) ||
                 ((bus.mem_op == MEM_LH || bus.mem_op == MEM_LHU || bus.mem_op == MEM_SH) && bus.A[0]));
        if (!rst_n) begin
            e_ov = 0; e_st = 0;
            e_w = 0; e_a = 0; e_sys = 0; e_we = 0; e_rw = 0;
        end else if (p_on) begin
            e_ov = !bus.flush;
            e_st = !bus.flush && !bus.go;
            e_w = mload(p_op, p_a); e_a = p_a; e_sys = p_sys; e_we = p_we; e_rw = p_rw;
        end else begin
            e_ov = bus.in_valid && !bus.flush && !is_load(bus.mem_op);
            e_st = bus.in_valid && !bus.flush && is_load(bus.mem_op);
            e_w = bus.A; e_a = bus.A; e_sys = bus.syscall; e_we = bus.WE; e_rw = bus.RW;
        end
        chk("m_out_valid", 32'(bus.out_valid), 32'(e_ov));
        chk("m_stall", 32'(bus.stall), 32'(e_st));
        chk("m_misalign", 32'(bus.misalign), 32'(e_mis));
        if (e_ov) begin
            chk("m_w_out", bus.w_out, e_w);
            chk("m_A_out", bus.A_out, e_a);
            chk("m_RW_out", 32'(bus.RW_out), 32'(e_rw));
            chk("m_WE_out", 32'(bus.WE_out), 32'(e_we));
            chk("m_syscall_out", 32'(bus.syscall_out), 32'(e_sys));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic g, input logic fl, input logic [3:0] rw,
                         input logic we, input logic sys);
        bus.in_valid = 1'b1;
        bus.mem_op   = op;
        bus.A        = a;
        bus.B        = b;
        bus.go       = g;
        bus.flush    = fl;
        bus.RW       = rw;
        bus.WE       = we;
        bus.syscall  = sys;
    endtask

    task automatic idle();
        drive(MEM_NONE, 32'h0, 32'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
    endtask

    task automatic st(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        drive(op, a, b, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        #3 chk("store_pass_valid", 32'(bus.out_valid), 32'd1);
        chk("store_stall", 32'(bus.stall), 32'd0);
        step();
    endtask

    task automatic do_load(input string nm, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] exp, input logic mis);
        drive(op, a, 32'h0, 1'b1, 1'b0, 4'd9, 1'b1, 1'b1);
        #3 chk({nm, "_issue_stall"}, 32'(bus.stall), 32'd1);
        chk({nm, "_issue_valid"}, 32'(bus.out_valid), 32'd0);
        chk({nm, "_misalign"}, 32'(bus.misalign), 32'(mis));
        step();
        #3 chk({nm, "_w_out"}, bus.w_out, exp);
        chk({nm, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({nm, "_stall"}, 32'(bus.stall), 32'd0);
        chk({nm, "_RW_out"}, 32'(bus.RW_out), 32'd9);
        step();
    endtask

    initial begin
        // Load request during reset must stay quiet.
        drive(MEM_LW, 32'h11, 32'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        #2 chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_misalign", 32'(bus.misalign), 32'd0);
        repeat (2) @(posedge clk);
        #1 idle();
        rst_n = 1'b1;
        step();

        st(MEM_SW, 32'h10, 32'hDEADBEEF);
        do_load("lw_basic", MEM_LW, 32'h10, 32'hDEADBEEF, 1'b0);

        st(MEM_SB, 32'h13, 32'h00000080);
        do_load("lb_13", MEM_LB, 32'h13, 32'hFFFFFF80, 1'b0);
        do_load("lbu_13", MEM_LBU, 32'h13, 32'h00000080, 1'b0);
        do_load("lw_after_sb", MEM_LW, 32'h10, 32'h80ADBEEF, 1'b0);

        st(MEM_SW, 32'h10, 32'h80011234);
        do_load("lh_12", MEM_LH, 32'h12, 32'hFFFF8001, 1'b0);
        do_load("lhu_12", MEM_LHU, 32'h12, 32'h00008001, 1'b0);
        do_load("lh_11_mis", MEM_LH, 32'h11, 32'h00001234, 1'b1);

        // ALU pass-through, then stores that must not land.
        drive(MEM_NONE, 32'h55, 32'hFFFFFFFF, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0);
        #3 chk("alu_valid", 32'(bus.out_valid), 32'd1);
        chk("alu_w_out", bus.w_out, 32'h55);
        chk("alu_stall", 32'(bus.stall), 32'd0);
        chk("alu_RW_out", 32'(bus.RW_out), 32'd3);
        step();
        drive(MEM_NONE, 32'h10, 32'hFFFFFFFF, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0);
        step();
        drive(MEM_SB, 32'h10, 32'h77, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        step();
        drive(MEM_SW, 32'h10, 32'hFFFFFFFF, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        #3 chk("flushed_store_valid", 32'(bus.out_valid), 32'd0);
        step();
        do_load("ram_unchanged", MEM_LW, 32'h10, 32'h80011234, 1'b0);

        // Held load: MEM/WB not accepting for three cycles.
        drive(MEM_LW, 32'h10, 32'h0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            #3 chk("hold_stall", 32'(bus.stall), 32'd1);
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_w_out", bus.w_out, 32'h80011234);
            step();
        end
        bus.go = 1'b1;
        #3 chk("hold_release_stall", 32'(bus.stall), 32'd0);
        step();
        drive(MEM_NONE, 32'h99, 32'h0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0);
        #3 chk("after_hold_w_out", bus.w_out, 32'h99);
        chk("after_hold_valid", 32'(bus.out_valid), 32'd1);
        step();

        // Flush while waiting.
        drive(MEM_LW, 32'h10, 32'h0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0);
        step();
        bus.flush = 1'b1;
        #3 chk("flush_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_stall", 32'(bus.stall), 32'd0);
        step();
        drive(MEM_NONE, 32'h77, 32'h0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0);
        #3 chk("after_flush_w_out", bus.w_out, 32'h77);
        chk("after_flush_valid", 32'(bus.out_valid), 32'd1);
        step();

        // Reset in the middle of a load.
        drive(MEM_LW, 32'h10, 32'h0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0);
        step();
        rst_n = 1'b0;
        #1 chk("midrst_stall", 32'(bus.stall), 32'd0);
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        idle();
        step();
        step();
        rst_n = 1'b1;
        step();

        st(MEM_SW, 32'h1010, 32'hCAFEF00D);
        do_load("wrap", MEM_LW, 32'h10, 32'hCAFEF00D, 1'b0);
        st(MEM_SH, 32'h12, 32'h0000ABCD);
        do_load("sh_upper", MEM_LW, 32'h10, 32'hABCDF00D, 1'b0);
        st(MEM_SH, 32'h11, 32'h00005555);
        do_load("sh_misaligned", MEM_LW, 32'h10, 32'hABCD5555, 1'b0);

        idle();
        step();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage between the EX/MEM pipeline buffer and the MEM/WB buffer.
- Owns the data RAM and performs word, halfword and byte loads and stores.
- Produces `w` (load data, or the ALU result passed through) for writeback, together with syscall/WE/RW/A.
- The RAM read is synchronous, so every load takes two cycles; a small FSM drives `stall` to freeze the upstream pipeline during that time.

Parameters:
- `ADDR_W`, 10, word-address width; RAM depth is 2^ADDR_W 32-bit words.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: EX/MEM holds a real instruction.
- `mem_op` in 4: 0 NONE, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 SW, 7 SH, 8 SB; others treated as NONE.
- `A` in 32: ALU result / byte address.
- `B` in 32: store data.
- `syscall` in 1: syscall flag.
- `WE` in 1: register-write enable.
- `RW` in 4: destination register.
- `go` in 1: MEM/WB accepts this cycle.
- `flush` in 1: squash the instruction in this stage.
- `stall` out 1: hold EX/MEM and earlier stages.
- `out_valid` out 1: outputs carry a completed instruction.
- `misalign` out 1: access address is not naturally aligned.
- `syscall_out` out 1, `WE_out` out 1, `RW_out` out 4, `A_out` out 32, `w_out` out 32: operands for MEM/WB.

Behaviour:
- **Reset.** `rst_n` low asynchronously:
  - FSM goes to IDLE; read-data register and load-control registers are cleared to 0.
  - While low: `stall`=0, `out_valid`=0, `misalign`=0, and RAM writes are suppressed.
  - RAM contents are not reset.
- **Addressing.**
  - Word index = `A[ADDR_W+1:2]`; upper bits are ignored, so addresses wrap modulo the RAM size.
  - Byte lane = `A[1:0]`, little-endian.
- **Alignment.**
  - `misalign`=1 when `in_valid` and (LW/SW with `A[1:0]`≠0, or LH/LHU/SH with `A[0]`=1).
  - The access still proceeds; the ignored low bits are forced to 0.
- **FSM states:** IDLE, LOAD_WAIT.
- **IDLE, non-load op (NONE or store):**
  - Combinational pass-through: `out_valid`=`in_valid`&~`flush`, `w_out`=`A`, `stall`=0.
  - `syscall_out`/`WE_out`/`RW_out`/`A_out` equal their inputs.
- **Stores.** Written at the rising edge when `in_valid`&`go`&~`flush`.
  - SW writes all 4 bytes.
  - SH writes lanes {1,0} or {3,2} with `B[15:0]`.
  - SB writes the lane selected by `A[1:0]` with `B[7:0]`.
  - Other bytes are unchanged.
- **IDLE, load op with `in_valid`&~`flush`:**
  - Issue RAM read; `stall`=1, `out_valid`=0.
  - Register mem_op, `A[1:0]`, syscall, WE, RW and A; next state LOAD_WAIT.
- **LOAD_WAIT:** the RAM read register holds the word.
  - `w_out` = extracted and extended data: LW whole word; LH/LB sign-extend; LHU/LBU zero-extend.
  - `out_valid`=1, `stall`=~`go`.
  - Other outputs come from the registered copies.
  - If `go`=1, go to IDLE next edge; else stay in LOAD_WAIT with data held stable.
- **Flush.** `flush` in LOAD_WAIT forces `out_valid`=0, `stall`=0, and IDLE next edge.
- **Latency.**
  - Loads: 2 cycles from issue to `out_valid` (1 stall cycle).
  - Other ops: 0 cycles (combinational).
- **Back-to-back loads.** The second load is held upstream by `stall` until the first completes. No load-to-load bypass is required, because RAM writes only occur in IDLE.
- **Reset mid-load.** Returns to IDLE; the load is lost.

Decomposition:
- Shared package (used by decoder, EX/MEM and mem_stage):
  - mem_op encoding constants (MEM_NONE … MEM_SB);
  - FSM state constants (S_IDLE, S_LOAD_WAIT).
- Sub-module `data_ram`:
  - 2^ADDR_W×32, 4 byte-write enables, synchronous registered read;
  - read register cleared by `rst_n`.
- Load extraction/extension stays inline in mem_stage.

Test Plan:
- SW `A`=0x10, `B`=0xDEADBEEF, `go`=1; then LW `A`=0x10 → 1 stall cycle, then `out_valid`=1, `w_out`=0xDEADBEEF, `stall`=0.
- SB `A`=0x13, `B`=0x80; then LB 0x13 → `w_out`=0xFFFFFF80; LBU 0x13 → `w_out`=0x00000080; LW 0x10 → `w_out`=0x80ADBEEF.
- LH `A`=0x12 after SW 0x8001_1234 at 0x10 → `w_out`=0xFFFF8001; LHU 0x12 → 0x00008001; LH 0x11 → `misalign`=1, data from lanes {1,0} = 0x00001234.
- ALU op (`mem_op`=NONE), `A`=0x55, `RW`=3, `WE`=1 → same cycle `out_valid`=1, `w_out`=0x55, `stall`=0, RAM unchanged.
- LW with `go`=0 held 3 cycles in LOAD_WAIT → `stall`=1 throughout, `w_out` stable; `go`=1 → IDLE next edge. Repeat with `flush`=1 in LOAD_WAIT → `out_valid`=0, IDLE next edge.
- Assert `rst_n`=0 mid-load (LOAD_WAIT) → immediately `stall`=0, `out_valid`=0; after release, SW to `A`=(2^ADDR_W)*4+0x10 then LW 0x10 returns the stored value (wrap).
